// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package lsu_pkg;

   typedef enum logic [1:0] {StIdle, StReq, StDone} lsu_state_e;

   localparam int unsigned TimeoutCyclesDefault = 16;
   localparam logic [1:0]  AlignMask            = 2'b00;
   localparam logic [31:0] AbortLoadData        = 32'h0;

   function automatic logic is_aligned(logic [1:0] addr_lsb);
      return addr_lsb == AlignMask;
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-aligned data-memory port with a req/ack handshake and variable latency.
interface load_store_unit_if;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_ack,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_ack,
      output mem_rdata
   );

endinterface

// File: rtl/lsu_timeout_cnt.sv
// Counts request cycles without acknowledge; expired_o flags the cycle whose
// increment would bring the count to TIMEOUT_CYCLES.
module lsu_timeout_cnt
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam logic [7:0] LastCount = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = 8'd0;
      end else if (en_i) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = en_i & (cnt_q == LastCount);

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: latches one access, drives the memory
// request, stalls until ack or timeout, and pulses valid_o on completion.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               MemRead_i,
   input  logic               MemWrite_i,
   input  logic [31:0]        addr_i,
   input  logic [31:0]        data_i,
   output logic               stall_o,
   output logic [31:0]        data_o,
   output logic               valid_o,
   output logic               misalign_o,
   output logic               timeout_o,
   load_store_unit_if.master  mem
);

   lsu_state_e  state_q;
   logic        req_q, we_q;
   logic [31:0] addr_q, wdata_q, data_q;
   logic        valid_q, misalign_q, timeout_q;

   logic access, aligned, accept, cnt_en, expired;

   assign access  = MemRead_i | MemWrite_i;
   assign aligned = is_aligned(addr_i[1:0]);
   assign accept  = (state_q == StIdle) & access & aligned;
   assign cnt_en  = (state_q == StReq) & ~mem.mem_ack;

   lsu_timeout_cnt #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout_cnt (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr_i     (accept),
      .en_i      (cnt_en),
      .expired_o (expired)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= StIdle;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         data_q     <= 32'h0;
         valid_q    <= 1'b0;
         misalign_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         valid_q    <= 1'b0;
         misalign_q <= 1'b0;
         timeout_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (access && aligned) begin
                  // Read+write together is a store; we_q follows MemWrite_i only.
                  addr_q  <= addr_i;
                  wdata_q <= data_i;
                  we_q    <= MemWrite_i;
                  req_q   <= 1'b1;
                  state_q <= StReq;
               end else if (access) begin
                  misalign_q <= 1'b1;
               end
            end
            StReq: begin
               if (mem.mem_ack) begin
                  if (!we_q) data_q <= mem.mem_rdata;
                  req_q   <= 1'b0;
                  valid_q <= 1'b1;
                  state_q <= StDone;
               end else if (expired) begin
                  if (!we_q) data_q <= AbortLoadData;
                  req_q     <= 1'b0;
                  valid_q   <= 1'b1;
                  timeout_q <= 1'b1;
                  state_q   <= StDone;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Combinational so the instruction is held from its very first MEM cycle.
   assign stall_o = (state_q == StReq) | accept;

   assign data_o     = data_q;
   assign valid_o    = valid_q;
   assign misalign_o = misalign_q;
   assign timeout_o  = timeout_q;

   assign mem.mem_req   = req_q;
   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table, scoreboard of
// completions, and hand-written stray-ack and mid-access reset sequences.
module tb_load_store_unit;
   import lsu_pkg::*;

   localparam int unsigned Tmo = 4;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          ack_at;  // REQ cycle carrying the ack; 0 = never
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic        tmo;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_read = 1'b0, mem_write = 1'b0;
   logic [31:0] addr = 32'h0, wdata = 32'h0;
   logic        stall_o, valid_o, misalign_o, timeout_o;
   logic [31:0] data_o;

   load_store_unit_if mem_bus ();

   load_store_unit #(
      .TIMEOUT_CYCLES (Tmo)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst_n),
      .MemRead_i  (mem_read),
      .MemWrite_i (mem_write),
      .addr_i     (addr),
      .data_i     (wdata),
      .stall_o    (stall_o),
      .data_o     (data_o),
      .valid_o    (valid_o),
      .misalign_o (misalign_o),
      .timeout_o  (timeout_o),
      .mem        (mem_bus)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_fail = 0;
   logic [31:0] model_data = 32'h0;
   exp_t        sb_q[$];
   exp_t        mon_e;
   vec_t        vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Completion monitor: every valid_o pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n) begin
         if (valid_o) begin
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL stray_valid: got valid_o=1 expected 0");
            end else begin
               mon_e = sb_q.pop_front();
               chk("sb_data", data_o, mon_e.data);
               chk("sb_timeout", 32'(timeout_o), 32'(mon_e.tmo));
            end
         end else if (timeout_o) begin
            chk("timeout_without_valid", 32'(timeout_o), 32'h0);
         end
      end
   end

   task automatic run_vec(input vec_t v);
      logic al, tmo;
      int   req_n, stall_n, done_c, exp_req;
      exp_t e;
      al  = (v.addr[1:0] == 2'b00);
      tmo = (v.ack_at == 0);
      @(posedge clk); #1;
      mem_read  = v.rd;
      mem_write = v.wr;
      addr      = v.addr;
      wdata     = v.wdata;
      if (al) begin
         e.tmo  = tmo;
         e.data = model_data;
         if (!v.wr) e.data = tmo ? 32'h0 : v.rdata;
         model_data = e.data;
         sb_q.push_back(e);
      end
      #1;
      chk("stall_cycle0", 32'(stall_o), 32'(al));
      stall_n = stall_o ? 1 : 0;
      if (!al) begin
         @(posedge clk); #1;
         mem_read  = 1'b0;
         mem_write = 1'b0;
         chk("misalign_pulse", 32'(misalign_o), 32'h1);
         chk("misalign_no_req", 32'(mem_bus.mem_req), 32'h0);
         chk("misalign_no_stall", 32'(stall_o), 32'h0);
         @(posedge clk); #1;
         chk("misalign_one_cycle", 32'(misalign_o), 32'h0);
         chk("misalign_no_req2", 32'(mem_bus.mem_req), 32'h0);
         return;
      end
      req_n  = 0;
      done_c = 0;
      for (int c = 1; c <= int'(Tmo) + 8 && done_c == 0; c++) begin
         @(posedge clk); #1;
         mem_bus.mem_ack = 1'b0;
         if (stall_o) stall_n++;
         if (valid_o) begin
            done_c    = c;
            mem_read  = 1'b0;
            mem_write = 1'b0;
         end else if (mem_bus.mem_req) begin
            req_n++;
            chk("mem_addr", mem_bus.mem_addr, v.addr);
            chk("mem_we", 32'(mem_bus.mem_we), 32'(v.wr));
            chk("mem_wdata", mem_bus.mem_wdata, v.wdata);
            if (req_n == v.ack_at) begin
               mem_bus.mem_ack   = 1'b1;
               mem_bus.mem_rdata = v.rdata;
            end
         end
      end
      exp_req = tmo ? int'(Tmo) : v.ack_at;
      chk("req_cycles", 32'(req_n), 32'(exp_req));
      chk("done_cycle", 32'(done_c), 32'(exp_req + 1));
      chk("stall_cycles", 32'(stall_n), 32'(exp_req + 1));
   endtask

   initial begin
      mem_bus.mem_ack   = 1'b0;
      mem_bus.mem_rdata = 32'h0;

      vecs[0] = '{rd:1'b1, wr:1'b0, addr:32'h8,  wdata:32'h0,         rdata:32'h1234_5678, ack_at:1};
      vecs[1] = '{rd:1'b0, wr:1'b1, addr:32'h1C, wdata:32'hCAFE_F00D, rdata:32'hBAD0_BAD0, ack_at:4};
      vecs[2] = '{rd:1'b1, wr:1'b0, addr:32'h6,  wdata:32'h0,         rdata:32'h0,         ack_at:1};
      vecs[3] = '{rd:1'b1, wr:1'b0, addr:32'h10, wdata:32'h0,         rdata:32'h7777_7777, ack_at:0};
      vecs[4] = '{rd:1'b1, wr:1'b1, addr:32'h4,  wdata:32'h0000_55AA, rdata:32'hBAD1_BAD1, ack_at:2};
      vecs[5] = '{rd:1'b1, wr:1'b0, addr:32'h20, wdata:32'h0,         rdata:32'hA5A5_A5A5, ack_at:3};
      vecs[6] = '{rd:1'b0, wr:1'b1, addr:32'h3,  wdata:32'h1111_2222, rdata:32'h0,         ack_at:1};
      vecs[7] = '{rd:1'b0, wr:1'b1, addr:32'h24, wdata:32'h3333_4444, rdata:32'hBAD2_BAD2, ack_at:0};

      #12;
      chk("rst_data", data_o, 32'h0);
      chk("rst_valid", 32'(valid_o), 32'h0);
      chk("rst_misalign", 32'(misalign_o), 32'h0);
      chk("rst_timeout", 32'(timeout_o), 32'h0);
      chk("rst_req", 32'(mem_bus.mem_req), 32'h0);
      chk("rst_we", 32'(mem_bus.mem_we), 32'h0);
      chk("rst_addr", mem_bus.mem_addr, 32'h0);
      chk("rst_wdata", mem_bus.mem_wdata, 32'h0);
      chk("rst_stall", 32'(stall_o), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Late ack after the store timeout, through DONE and IDLE: must be ignored.
      mem_bus.mem_ack   = 1'b1;
      mem_bus.mem_rdata = 32'hDEAD_BEEF;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk("stray_ack_no_req", 32'(mem_bus.mem_req), 32'h0);
         chk("stray_ack_no_stall", 32'(stall_o), 32'h0);
      end
      mem_bus.mem_ack = 1'b0;
      chk("stray_ack_data", data_o, model_data);

      // Reset in the middle of a load with the ack arriving during reset.
      @(posedge clk); #1;
      mem_read = 1'b1;
      addr     = 32'h30;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_reset_req", 32'(mem_bus.mem_req), 32'h1);
      #2;
      rst_n             = 1'b0;
      mem_bus.mem_ack   = 1'b1;
      mem_bus.mem_rdata = 32'h5555_5555;
      #1;
      chk("async_req_drop", 32'(mem_bus.mem_req), 32'h0);
      chk("async_data", data_o, 32'h0);
      chk("async_addr", mem_bus.mem_addr, 32'h0);
      chk("async_valid", 32'(valid_o), 32'h0);
      mem_read = 1'b0;
      #1;
      chk("async_stall", 32'(stall_o), 32'h0);
      model_data = 32'h0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      mem_bus.mem_ack = 1'b0;
      rst_n           = 1'b1;
      chk("post_reset_valid", 32'(valid_o), 32'h0);

      run_vec('{rd:1'b1, wr:1'b0, addr:32'h40, wdata:32'h0, rdata:32'h0BAD_F00D, ack_at:2});

      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("sb_drained", 32'(sb_q.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL global_timeout: got no end of test expected completion");
      $fatal(1, "bench time limit");
   end

endmodule
